// File: rtl/fir_serial_to_parallel3.sv
// Serial-to-3-parallel input packer for the unfolded FIR.
// Collects three valid samples and presents them as one triple with a single-cycle vout.
//
// state | meaning
// ------+------------------------------------------------------------------
// PH0   | next valid sample is lane 0 (x[3k]) and is held in h0
// PH1   | next valid sample is lane 1 (x[3k+1]) and is held in h1
// PH2   | next valid sample is lane 2 (x[3k+2]); the triple is emitted
// PH3   | unreachable; treated exactly like PH0
module fir_serial_to_parallel3 #(
    parameter int NBIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBIT-1:0] din,
    input  logic            vin,
    input  logic            clr,
    output logic [NBIT-1:0] dout3k,
    output logic [NBIT-1:0] dout3k1,
    output logic [NBIT-1:0] dout3k2,
    output logic            vout,
    output logic [1:0]      phase
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t          phase_q, phase_nxt;
    logic [NBIT-1:0] h0_q, h0_nxt;
    logic [NBIT-1:0] h1_q, h1_nxt;
    logic [NBIT-1:0] d0_q, d0_nxt;
    logic [NBIT-1:0] d1_q, d1_nxt;
    logic [NBIT-1:0] d2_q, d2_nxt;
    logic            vout_q, vout_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH0;
            h0_q    <= '0;
            h1_q    <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            vout_q  <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            h0_q    <= h0_nxt;
            h1_q    <= h1_nxt;
            d0_q    <= d0_nxt;
            d1_q    <= d1_nxt;
            d2_q    <= d2_nxt;
            vout_q  <= vout_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase_q;
        h0_nxt    = h0_q;
        h1_nxt    = h1_q;
        d0_nxt    = d0_q;
        d1_nxt    = d1_q;
        d2_nxt    = d2_q;
        vout_nxt  = 1'b0;

        if (clr) begin
            // Realign drops the partial group; a sample arriving with clr starts the new one.
            h1_nxt = '0;
            if (vin) begin
                h0_nxt    = din;
                phase_nxt = PH1;
            end else begin
                h0_nxt    = '0;
                phase_nxt = PH0;
            end
        end else if (vin) begin
            case (phase_q)
                PH1: begin
                    h1_nxt    = din;
                    phase_nxt = PH2;
                end
                PH2: begin
                    d0_nxt    = h0_q;
                    d1_nxt    = h1_q;
                    d2_nxt    = din;
                    vout_nxt  = 1'b1;
                    phase_nxt = PH0;
                end
                default: begin
                    h0_nxt    = din;
                    phase_nxt = PH1;
                end
            endcase
        end
    end

    assign dout3k  = d0_q;
    assign dout3k1 = d1_q;
    assign dout3k2 = d2_q;
    assign vout    = vout_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_fir_serial_to_parallel3.sv
// Directed bench for fir_serial_to_parallel3: a behavioural model pushes expected
// triples into a queue as stimulus is driven; they are popped when vout fires.
module tb_fir_serial_to_parallel3;

    localparam int NBIT = 8;

    logic            clk;
    logic            rst_n;
    logic [NBIT-1:0] din;
    logic            vin;
    logic            clr;
    logic [NBIT-1:0] dout3k;
    logic [NBIT-1:0] dout3k1;
    logic [NBIT-1:0] dout3k2;
    logic            vout;
    logic [1:0]      phase;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];
    logic [23:0] last_trip;
    logic [1:0]  m_ph;
    logic [7:0]  m_h0, m_h1;

    fir_serial_to_parallel3 #(.NBIT(NBIT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .vin     (vin),
        .clr     (clr),
        .dout3k  (dout3k),
        .dout3k1 (dout3k1),
        .dout3k2 (dout3k2),
        .vout    (vout),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic cyc(input logic [7:0] d, input logic v, input logic c);
        logic       pulse;
        logic [23:0] t;
        din = d;
        vin = v;
        clr = c;
        pulse = 1'b0;
        if (c) begin
            if (v) begin
                m_h0 = d;
                m_ph = 2'd1;
            end else begin
                m_ph = 2'd0;
            end
        end else if (v) begin
            case (m_ph)
                2'd0: begin m_h0 = d; m_ph = 2'd1; end
                2'd1: begin m_h1 = d; m_ph = 2'd2; end
                default: begin
                    exp_q.push_back({m_h0, m_h1, d});
                    m_ph  = 2'd0;
                    pulse = 1'b1;
                end
            endcase
        end
        @(posedge clk);
        #1;
        chk("vout", {31'd0, vout}, {31'd0, pulse});
        if (vout === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_triple", {8'd0, dout3k, dout3k1, dout3k2}, 32'hDEAD_BEEF);
            end else begin
                t = exp_q.pop_front();
                last_trip = t;
            end
        end
        chk("lanes", {8'd0, dout3k, dout3k1, dout3k2}, {8'd0, last_trip});
        chk("phase", {30'd0, phase}, {30'd0, m_ph});
        din = '0;
        vin = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        din = '0;
        vin = 1'b0;
        clr = 1'b0;
        m_ph = 2'd0;
        m_h0 = '0;
        m_h1 = '0;
        last_trip = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lanes", {8'd0, dout3k, dout3k1, dout3k2}, 32'd0);
        chk("rst_vout", {31'd0, vout}, 32'd0);
        chk("rst_phase", {30'd0, phase}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back samples: two triples, 3 cycles apart.
        for (int i = 1; i <= 6; i++) cyc(8'(i), 1'b1, 1'b0);
        chk("seq_second_triple", {8'd0, dout3k, dout3k1, dout3k2}, 32'h040506);
        cyc(8'h00, 1'b0, 1'b0);

        // Gapped input.
        cyc(8'h10, 1'b1, 1'b0);
        repeat (2) cyc(8'hEE, 1'b0, 1'b0);
        cyc(8'h20, 1'b1, 1'b0);
        repeat (5) cyc(8'hEE, 1'b0, 1'b0);
        cyc(8'h30, 1'b1, 1'b0);
        chk("gap_triple", {8'd0, dout3k, dout3k1, dout3k2}, 32'h102030);

        // Signed pass-through, then hold during idle.
        cyc(8'h80, 1'b1, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0);
        cyc(8'h7F, 1'b1, 1'b0);
        repeat (10) cyc(8'h55, 1'b0, 1'b0);
        chk("signed_hold", {8'd0, dout3k, dout3k1, dout3k2}, 32'h80FF7F);

        // Realign with a sample on the clr edge.
        cyc(8'hAA, 1'b1, 1'b0);
        cyc(8'hBB, 1'b1, 1'b0);
        cyc(8'h01, 1'b1, 1'b1);
        cyc(8'h02, 1'b1, 1'b0);
        cyc(8'h03, 1'b1, 1'b0);
        chk("clr_triple", {8'd0, dout3k, dout3k1, dout3k2}, 32'h010203);

        // Realign with no sample while at phase 2.
        cyc(8'hC1, 1'b1, 1'b0);
        cyc(8'hC2, 1'b1, 1'b0);
        chk("pre_clr_phase", {30'd0, phase}, 32'd2);
        cyc(8'hC3, 1'b0, 1'b1);
        chk("clr_idle_phase", {30'd0, phase}, 32'd0);
        cyc(8'hD1, 1'b1, 1'b0);
        cyc(8'hD2, 1'b1, 1'b0);
        cyc(8'hD3, 1'b1, 1'b0);
        chk("post_clr_triple", {8'd0, dout3k, dout3k1, dout3k2}, 32'hD1D2D3);

        // Asynchronous reset mid-group.
        cyc(8'h11, 1'b1, 1'b0);
        cyc(8'h22, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lanes", {8'd0, dout3k, dout3k1, dout3k2}, 32'd0);
        chk("async_rst_vout", {31'd0, vout}, 32'd0);
        chk("async_rst_phase", {30'd0, phase}, 32'd0);
        m_ph = 2'd0;
        last_trip = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h33, 1'b1, 1'b0);
        cyc(8'h44, 1'b1, 1'b0);
        cyc(8'h55, 1'b1, 1'b0);
        chk("rst_recover_triple", {8'd0, dout3k, dout3k1, dout3k2}, 32'h334455);
        repeat (3) cyc(8'h00, 1'b0, 1'b0);

        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_serial_to_parallel3.md
Name: fir_serial_to_parallel3

Overview:
- Input packer that sits directly upstream of the 3-parallel unfolded FIR.
- Accepts a serial sample stream with a per-sample valid and groups every three consecutive valid samples into one parallel triple: x[3k], x[3k+1], x[3k+2].
- Presents each triple on three lane buses with a single-cycle valid that drives the FIR's din3k/din3k1/din3k2/vin inputs directly.
- Tracks the lane phase and supports a synchronous realign that discards any partial group.

Parameters:
- NBIT, 8, width of each sample and of each output lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NBIT  serial input sample, signed two's complement; passed through unmodified.
- vin  input  1  din valid; sample accepted on any rising edge with vin=1.
- clr  input  1  synchronous realign; discards the partial group and restarts the lane phase.
- dout3k  output  NBIT  lane 0: first sample of the group, x[3k].
- dout3k1  output  NBIT  lane 1: second sample of the group, x[3k+1].
- dout3k2  output  NBIT  lane 2: third sample of the group, x[3k+2].
- vout  output  1  one-cycle pulse marking a new valid triple on the dout lanes.
- phase  output  2  current lane index of the next sample to be accepted (0, 1 or 2).

Behaviour:
- Reset (rst_n=0, asynchronous): dout3k, dout3k1 and dout3k2 = 0; vout = 0; phase = 0; internal holding registers h0 and h1 = 0. Release is synchronous to the next clk edge.
- Phase counter, modulo 3, values 0→1→2→0. Value 3 is never reachable; if reached, treat it as 0.
- Per rising edge, with clr=0 and vin=1:
  - phase=0: h0 ← din; phase ← 1.
  - phase=1: h1 ← din; phase ← 2.
  - phase=2: dout3k ← h0, dout3k1 ← h1, dout3k2 ← din (all three in the same edge); vout ← 1; phase ← 0.
- Per rising edge, with clr=0 and vin=0:
  - Nothing changes except vout ← 0.
  - Gaps of any length between valid samples are allowed and do not break a group.
- vout is 1 for exactly the cycle after the third sample is accepted, and 0 otherwise.
- Latency: the triple appears at the outputs one clock after the edge that accepted x[3k+2].
- dout lanes hold their last triple until the next triple; they are never cleared except by reset.
- Sustained throughput at vin=1 every cycle: one triple every 3 cycles. vout never asserts on two consecutive cycles.
- clr=1 on an edge:
  - Any partially collected group (h0/h1 contents) is discarded; vout ← 0.
  - If vin=0: phase ← 0.
  - If vin=1: din is accepted as lane 0 of a new group, so h0 ← din and phase ← 1.
  - This applies even when phase=2: no triple is emitted.
- dout lanes are not modified by clr.
- Reset mid-group: the partial group is lost; the first valid sample after reset is x[0] (lane 0).
- No backpressure: the downstream FIR always accepts. There is no ready signal, and no overflow condition can occur.

Test Plan:
- Reset, then vin=1 every cycle with din = 1, 2, 3, 4, 5, 6 → vout pulses twice, 3 cycles apart. First triple: dout3k=1, dout3k1=2, dout3k2=3. Second triple: 4, 5, 6. phase sequence 0,1,2,0,1,2,0.
- Gapped input: din = 0x10, gap 2 cycles, 0x20, gap 5 cycles, 0x30 → a single vout one cycle after 0x30 with triple (0x10, 0x20, 0x30). vout=0 during all gaps.
- Signed pass-through: din = 0x80, 0xFF, 0x7F → triple (0x80, 0xFF, 0x7F), unaltered. Lanes hold these values for 10 idle cycles afterwards.
- Realign with clr:
  - Send 0xAA, 0xBB; then clr=1 with vin=1 and din=0x01; then 0x02, 0x03 → no vout for 0xAA/0xBB; next triple is (0x01, 0x02, 0x03).
  - clr=1 with vin=0 at phase=2 → phase=0, no vout.
- Reset mid-operation: after 0x11, 0x22 are accepted, assert rst_n=0 asynchronously between edges → outputs, vout and phase go to 0 immediately. After release, 0x33, 0x44, 0x55 yields triple (0x33, 0x44, 0x55).
- End-to-end with the unfolded FIR: feed 30 samples of an impulse (0x7F then zeros) through this block into the FIR → the FIR output lanes match the golden model of the 11-tap filter, interleaved in the order 3k, 3k+1, 3k+2.
